mem_bus_arbiter: RTL

// - Shares the single data-memory port (RAM port B + RTC/PLIC/TB regions) between N_REQ masters: the RS5 data port (req 0) and auxiliary masters (DMA/debug loader).
// - Round-robin arbitration, one access per cycle, address decode to target enables, registered response steering (1-cycle read latency).
// - Sits between the masters and the RAM/RTC/PLIC/TB slaves. A master not granted must hold its request; gnt_o[0] low drives the core stall input.

---
 rtl/mem_bus_arbiter_pkg.sv | 31 +++
 rtl/mem_bus_arbiter_decoder.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and region map for the data-memory bus arbiter.
// The region of an access is taken from the top address nibble.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      TGT_RAM  = 2'd0,
      TGT_RTC  = 2'd1,
      TGT_PLIC = 2'd2,
      TGT_TB   = 2'd3
   } mem_tgt_e;

   // Lowest top-nibble value of each region; RAM starts at 0.
   localparam logic [3:0] REGION_RTC_LO  = 4'h2;
   localparam logic [3:0] REGION_PLIC_LO = 4'h3;
   localparam logic [3:0] REGION_TB_LO   = 4'h8;

   function automatic mem_tgt_e decode_tgt(input logic [3:0] region);
      mem_tgt_e tgt;
      if (region < REGION_RTC_LO) begin
         tgt = TGT_RAM;
      end else if (region < REGION_PLIC_LO) begin
         tgt = TGT_RTC;
      end else if (region < REGION_TB_LO) begin
         tgt = TGT_PLIC;
      end else begin
         tgt = TGT_TB;
      end
      return tgt;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter_decoder.sv
// Address decoder: maps the top address nibble to a target and a
// one-hot set of slave enables, qualified by en.
module mem_bus_arbiter_decoder
   import mem_bus_arbiter_pkg::*;
(
   input  logic [3:0] region,
   input  logic       en,
   output mem_tgt_e   tgt,
   output logic       en_ram,
   output logic       en_rtc,
   output logic       en_plic,
   output logic       en_tb
);

   // Region lookup and one-hot enable generation.
   always_comb begin
      tgt     = decode_tgt(region);
      en_ram  = 1'b0;
      en_rtc  = 1'b0;
      en_plic = 1'b0;
      en_tb   = 1'b0;
      if (en) begin
         unique case (tgt)
            TGT_RAM:  en_ram  = 1'b1;
            TGT_RTC:  en_rtc  = 1'b1;
            TGT_PLIC: en_plic = 1'b1;
            TGT_TB:   en_tb   = 1'b1;
         endcase
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one data-memory port between N_REQ masters
// (master 0 is the core). Grant and slave selects are combinational; the
// response is steered back one cycle later from registered owner/target.
// Optional build macro ARB_LOCK_EN: a granted master holding lock_i keeps
// exclusive priority for up to LOCK_MAX consecutive grants.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int ADDR_W   = 32,
   parameter int LOCK_MAX = 16
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_REQ-1:0]     req_i,
   input  logic [N_REQ*4-1:0]   we_i,
   input  logic [N_REQ*ADDR_W-1:0] addr_i,
   input  logic [N_REQ*32-1:0]  wdata_i,
   input  logic [N_REQ-1:0]     lock_i,
   output logic [N_REQ-1:0]     gnt_o,
   output logic [N_REQ-1:0]     rvalid_o,
   output logic [31:0]          rdata_o,
   output logic                 en_ram_o,
   output logic                 en_rtc_o,
   output logic                 en_plic_o,
   output logic                 en_tb_o,
   output logic [3:0]           slv_we_o,
   output logic [ADDR_W-1:0]    slv_addr_o,
   output logic [31:0]          slv_wdata_o,
   input  logic [31:0]          ram_rdata_i,
   input  logic [31:0]          rtc_rdata_i,
   input  logic [31:0]          plic_rdata_i,
   input  logic [31:0]          tb_rdata_i
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [PTR_W-1:0] rr_ptr;
   logic [N_REQ-1:0] req_eff;
   logic             gnt_any;
   logic [PTR_W-1:0] gnt_idx;
   int               scan;
   mem_tgt_e         tgt;

   logic             resp_vld_p1;
   logic [PTR_W-1:0] resp_owner_p1;
   mem_tgt_e         resp_tgt_p1;

`ifdef ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic             lock_act;
   logic [PTR_W-1:0] lock_own;
   logic [CNT_W-1:0] lock_cnt;
   logic             lock_hold;
   logic [CNT_W-1:0] lock_cnt_nxt;

   // Locked owner keeps exclusive priority only while it still requests.
   always_comb begin
      lock_hold    = lock_act && req_i[lock_own];
      lock_cnt_nxt = CNT_W'(1);
      if (lock_act && (lock_own == gnt_idx)) begin
         lock_cnt_nxt = lock_cnt + CNT_W'(1);
      end
   end

   // Lock state: armed by a locked grant, dropped on unlock, idle owner or LOCK_MAX.
   always_ff @(posedge clk) begin
      if (reset) begin
         lock_act <= 1'b0;
         lock_own <= '0;
         lock_cnt <= '0;
      end else if (gnt_any && lock_i[gnt_idx] && (lock_cnt_nxt != CNT_W'(LOCK_MAX))) begin
         lock_act <= 1'b1;
         lock_own <= gnt_idx;
         lock_cnt <= lock_cnt_nxt;
      end else begin
         lock_act <= 1'b0;
         lock_cnt <= '0;
      end
   end
`else
   localparam int lock_max_unused = LOCK_MAX;
   logic lock_unused;
   assign lock_unused = ^lock_i;
`endif

   // Pick the first eligible requester at or after rr_ptr, wrapping around.
   always_comb begin
      req_eff = reset ? '0 : req_i;
`ifdef ARB_LOCK_EN
      if (!reset && lock_hold) begin
         req_eff           = '0;
         req_eff[lock_own] = 1'b1;
      end
`endif
      gnt_any = 1'b0;
      gnt_idx = '0;
      scan    = 0;
      for (int i = 0; i < N_REQ; i++) begin
         scan = int'(rr_ptr) + i;
         if (scan >= N_REQ) begin
            scan = scan - N_REQ;
         end
         if (!gnt_any && req_eff[scan[PTR_W-1:0]]) begin
            gnt_any = 1'b1;
            gnt_idx = scan[PTR_W-1:0];
         end
      end
   end

   // Route the granted master onto the slave bus; bus idles at zero.
   always_comb begin
      gnt_o       = '0;
      slv_we_o    = '0;
      slv_addr_o  = '0;
      slv_wdata_o = '0;
      if (gnt_any) begin
         gnt_o[gnt_idx] = 1'b1;
         for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == PTR_W'(i)) begin
               slv_we_o    = we_i[i*4 +: 4];
               slv_addr_o  = addr_i[i*ADDR_W +: ADDR_W];
               slv_wdata_o = wdata_i[i*32 +: 32];
            end
         end
      end
   end

   mem_bus_arbiter_decoder u_decoder (
      .region  (slv_addr_o[ADDR_W-1 -: 4]),
      .en      (gnt_any),
      .tgt     (tgt),
      .en_ram  (en_ram_o),
      .en_rtc  (en_rtc_o),
      .en_plic (en_plic_o),
      .en_tb   (en_tb_o)
   );

   // Round-robin pointer moves just past the master served this cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr <= '0;
      end else if (gnt_any) begin
         rr_ptr <= (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

   // ---- grant -> response boundary (p1) ----
   // Response valid is control and resets; owner/target are payload only.
   always_ff @(posedge clk) begin
      if (reset) begin
         resp_vld_p1 <= 1'b0;
      end else begin
         resp_vld_p1 <= gnt_any;
      end
   end

   // Capture who was served and which slave answers next cycle.
   always_ff @(posedge clk) begin
      if (gnt_any) begin
         resp_owner_p1 <= gnt_idx;
         resp_tgt_p1   <= tgt;
      end
   end

   // Steer the slave's read data back to the owner; suppressed during reset.
   always_comb begin
      rvalid_o = '0;
      rdata_o  = '0;
      if (resp_vld_p1 && !reset) begin
         rvalid_o[resp_owner_p1] = 1'b1;
         unique case (resp_tgt_p1)
            TGT_RAM:  rdata_o = ram_rdata_i;
            TGT_RTC:  rdata_o = rtc_rdata_i;
            TGT_PLIC: rdata_o = plic_rdata_i;
            TGT_TB:   rdata_o = tb_rdata_i;
         endcase
      end
   end

endmodule
